// File: rtl/piezo_pkg.sv
// Shared types and the fixed note table for the piezo tune sequencer.
package piezo_pkg;

    localparam int TICK_CNT_DFLT  = 500000;
    localparam int NUM_NOTES_DFLT = 8;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

    typedef struct packed {
        logic [14:0] per;
        logic [7:0]  dur;
    } note_t;

    // dur==0 marks the end of the tune
    localparam note_t TUNE [NUM_NOTES_DFLT] = '{
        '{per: 15'd23889, dur: 8'd10},
        '{per: 15'd18961, dur: 8'd10},
        '{per: 15'd15944, dur: 8'd10},
        '{per: 15'd11945, dur: 8'd20},
        '{per: 15'd0,     dur: 8'd0},
        '{per: 15'd0,     dur: 8'd0},
        '{per: 15'd0,     dur: 8'd0},
        '{per: 15'd0,     dur: 8'd0}
    };

    // Entries past the table read as end-of-tune markers.
    function automatic note_t tune_at(input int i);
        logic [2:0] sel;
        sel = i[2:0];
        if (i < 0 || i >= NUM_NOTES_DFLT) return '0;
        return TUNE[sel];
    endfunction

endpackage

// File: rtl/piezo_tune_seq_if.sv
// Control/handshake bundle between the tune sequencer and its surroundings.
interface piezo_tune_seq_if #(parameter int NUM_NOTES = 8);
    localparam int IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

    logic          start;
    logic          abort;
    logic          note_over;
    logic          tick_en;
    logic          dur_clr;
    logic [7:0]    note_dur;
    logic [14:0]   note_per;
    logic          sound_en;
    logic [IW-1:0] note_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, note_over,
        input  tick_en, dur_clr, note_dur, note_per, sound_en, note_idx, busy, done
    );

    modport slave (
        input  start, abort, note_over,
        output tick_en, dur_clr, note_dur, note_per, sound_en, note_idx, busy, done
    );
endinterface

// File: rtl/piezo_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_CNT clocks.
module piezo_tick_gen #(
    parameter int TICK_CNT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_CNT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)  cnt <= '0;
        else if (tick)   cnt <= '0;
        else             cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/piezo_tune_seq.sv
// Steps through the note table, driving the duration counter's enable/clear
// and inserting silent gaps between notes.
module piezo_tune_seq
    import piezo_pkg::*;
#(
    parameter int TICK_CNT  = TICK_CNT_DFLT,
    parameter int GAP_TICKS = 2,
    parameter int NUM_NOTES = NUM_NOTES_DFLT
) (
    input logic            clk,
    input logic            rst,
    piezo_tune_seq_if.slave bus
);
    localparam int IW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
    localparam int GW = $clog2(GAP_TICKS) + 1;

    state_t        state, state_nx;
    logic          tick, pre_clr, gap_last, last_note;
    logic [IW-1:0] idx;
    logic [GW-1:0] gap_cnt;
    note_t         cur, nxt;
    logic          busy_q, done_q;

    assign pre_clr = (state == IDLE) || (state == LOAD);

    piezo_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign nxt       = tune_at(int'(idx) + 1);
    assign gap_last  = tick && (gap_cnt == GW'(GAP_TICKS - 1));
    assign last_note = (int'(idx) == NUM_NOTES - 1) || (nxt.dur == 8'd0);

    always_comb begin
        state_nx     = state;
        bus.tick_en  = 1'b0;
        bus.dur_clr  = 1'b0;
        bus.sound_en = 1'b0;
        unique case (state)
            IDLE: if (bus.start && !bus.abort) state_nx = LOAD;
            LOAD: begin
                // the duration counter only loads when enabled, so clear rides on an enable
                bus.tick_en = 1'b1;
                bus.dur_clr = 1'b1;
                state_nx    = PLAY;
            end
            PLAY: begin
                bus.tick_en  = tick;
                bus.sound_en = (cur.per != 15'd0);
                if (bus.note_over) state_nx = GAP;
            end
            GAP:  if (gap_last) state_nx = last_note ? DONE : LOAD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            cur     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            if (state == IDLE && state_nx == LOAD) idx <= '0;
            if (state == GAP  && state_nx == LOAD) idx <= idx + 1'b1;
            if (state == LOAD && state_nx == PLAY) cur <= tune_at(int'(idx));
            if (state != GAP)  gap_cnt <= '0;
            else if (tick)     gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign bus.note_idx = idx;
    assign bus.note_dur = cur.dur;
    assign bus.note_per = cur.per;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
